load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter noal, default 8, meaning the number of byte-address lines of the data memory.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every state change occurs on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1, pipeline memory request present.
REQ-005 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3, RV32I access type: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
REQ-008 The block SHALL have port req_addr, input, noal, byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, store data in bits [7:0], [15:0] or [31:0].
REQ-010 The block SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata, output, 32, extended load result.
REQ-012 The block SHALL have port resp_err, output, 1, misaligned or illegal access, valid with resp_valid.
REQ-013 The block SHALL have port memread, output, 1, read strobe to the data memory.
REQ-014 The block SHALL have port memwrite, output, 1, write strobe to the data memory.
REQ-015 The block SHALL have port address, output, noal, word-aligned memory address.
REQ-016 The block SHALL have port write_data, output, 32, little-endian word to the memory.
REQ-017 The block SHALL have port read_data, input, 32, combinational little-endian word from the memory.

Function
REQ-018 The block SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid and req_ready high at a rising edge.
REQ-020 On a handshake, the block SHALL capture we, funct3, addr and wdata into internal registers.
REQ-021 The request SHALL be an error if any of these hold: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3>=3.
REQ-022 IDLE transitions on a handshake SHALL be: error -> RESP; load -> READ; SB or SH -> READ; SW -> WRITE.
REQ-023 An erroneous request SHALL never assert memread or memwrite.
REQ-024 address SHALL equal {captured addr[noal-1:2], 2'b00} whenever memread or memwrite is 1.
REQ-025 address SHALL be 0 otherwise.
REQ-026 READ SHALL assert memread=1 for exactly one cycle and latch read_data at the end of that cycle.
REQ-027 From READ, a load SHALL go to RESP and a store SHALL go to WRITE.
REQ-028 WRITE SHALL assert memwrite=1 for exactly one cycle, then go to RESP.
REQ-029 For SW, write_data SHALL be wdata.
REQ-030 For SB and SH, write_data SHALL be the latched word with only the addressed byte lane (addr[1:0]) or halfword lane (addr[1]) replaced by wdata[7:0] or wdata[15:0].
REQ-031 write_data SHALL be 0 outside WRITE.
REQ-032 memread and memwrite SHALL never be 1 in the same cycle.
REQ-033 RESP SHALL assert resp_valid=1 for exactly one cycle, then go to IDLE.
REQ-034 The block SHALL provide no back-pressure on the response.
REQ-035 For a load, resp_rdata SHALL be the selected byte or halfword of the latched word: sign-extended for LB/LH, zero-extended for LBU/LHU, the full word for LW.
REQ-036 For a store or an error, resp_rdata SHALL be 0.
REQ-037 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-038 Latency from handshake edge to resp_valid SHALL be: load 2 cycles; SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
REQ-039 A new handshake SHALL be possible in the cycle after RESP, giving back-to-back loads 3 cycles apart.
REQ-040 req_valid SHALL be ignored outside IDLE; the requester holds the request until req_ready.

Reset
REQ-041 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-042 When rst_n=0 at a rising edge, resp_valid, resp_err, resp_rdata and the latched word SHALL become 0.
REQ-043 In the first cycle after reset, memread=0, memwrite=0, address=0, write_data=0 and req_ready=1 SHALL hold.
REQ-044 Reset asserted in READ or WRITE SHALL abort the access: no further memwrite and no resp_valid for the aborted request.

Verification
REQ-045 Memory word 0x04=0x8000_00F2; LB addr 0x04 -> memread pulse at address 0x04, resp_rdata=0xFFFF_FFF2, resp_err=0, resp 2 cycles after handshake.
REQ-046 Same word; LBU addr 0x04 -> 0x0000_00F2; LHU addr 0x06 -> 0x0000_8000; LH addr 0x06 -> 0xFFFF_8000.
REQ-047 Memory word 0x08=0x0000_0003; SB addr 0x09 wdata 0xAB -> memread at 0x08, then memwrite with write_data=0x0000_AB03, resp 3 cycles after handshake.
REQ-048 SW addr 0x0C wdata 0xDEAD_BEEF -> no memread, one memwrite pulse at 0x0C with data 0xDEAD_BEEF; a following LW at 0x0C returns 0xDEAD_BEEF.
REQ-049 LW addr 0x02 and SH addr 0x05 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after handshake, memread=memwrite=0 throughout.
REQ-050 SB issued, rst_n=0 during the READ cycle -> no memwrite, no resp_valid, req_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, byte/halfword stores done
// as read-modify-write of the containing word.
module load_store_unit #(
    parameter int noal = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [noal-1:0] req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic            memread,
    output logic            memwrite,
    output logic [noal-1:0] address,
    output logic [31:0]     write_data,
    input  logic [31:0]     read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t          state, state_nx;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [noal-1:0] addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     word_q;
    logic            hs;
    logic            req_bad;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_val;
    logic [31:0]     st_word;

    assign hs        = req_valid && req_ready;
    assign req_ready = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign memread   = (state == READ);
    assign memwrite  = (state == WRITE);
    assign address   = (memread || memwrite) ? {addr_q[noal-1:2], 2'b00} : '0;
    assign write_data = memwrite ? st_word : 32'h0;

    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'd0:    req_bad = 1'b0;
            3'd1:    req_bad = req_addr[0];
            3'd2:    req_bad = (req_addr[1:0] != 2'b00);
            3'd4:    req_bad = req_we;
            3'd5:    req_bad = req_we || req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = 8'h0;
        ld_half = addr_q[1] ? read_data[31:16] : read_data[15:0];
        unique case (addr_q[1:0])
            2'd0: ld_byte = read_data[7:0];
            2'd1: ld_byte = read_data[15:8];
            2'd2: ld_byte = read_data[23:16];
            2'd3: ld_byte = read_data[31:24];
        endcase
        case (f3_q[1:0])
            2'd0:    ld_val = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
            2'd1:    ld_val = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
            default: ld_val = read_data;
        endcase
    end

    // Sub-word stores patch only the addressed lane of the word read earlier.
    always_comb begin
        st_word = word_q;
        case (f3_q[1:0])
            2'd0: begin
                unique case (addr_q[1:0])
                    2'd0: st_word[7:0]   = wdata_q[7:0];
                    2'd1: st_word[15:8]  = wdata_q[7:0];
                    2'd2: st_word[23:16] = wdata_q[7:0];
                    2'd3: st_word[31:24] = wdata_q[7:0];
                endcase
            end
            2'd1: begin
                if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
                else           st_word[15:0]  = wdata_q[15:0];
            end
            default: st_word = wdata_q;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    if (req_bad)
                        state_nx = RESP;
                    else if (req_we && req_funct3 == 3'd2)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ:  state_nx = we_q ? WRITE : RESP;
            WRITE: state_nx = RESP;
            RESP:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == READ)
                word_q <= read_data;
            if (state != RESP && state_nx == RESP) begin
                resp_err   <= (state == IDLE);
                resp_rdata <= (state == READ && !we_q) ? ld_val : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memread;
    logic        memwrite;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    logic [31:0] mem [0:63];

    int n_vec = 0;
    int n_bad = 0;

    int          lat, nrd, nwr, both;
    logic [7:0]  rd_addr, wr_addr;
    logic [31:0] wr_data, got_rdata;
    logic        got_err;

    always #5 clk = ~clk;

    load_store_unit #(.noal(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .memread(memread), .memwrite(memwrite),
        .address(address), .write_data(write_data),
        .read_data(read_data)
    );

    assign read_data = mem[address[7:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[1] <= 32'h8000_00F2;
            mem[2] <= 32'h0000_0003;
            mem[3] <= 32'h0;
        end else if (memwrite) begin
            mem[address[7:2]] <= write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [7:0] a, input logic [31:0] wd);
        int w;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0;
        rd_addr = 8'h0; wr_addr = 8'h0; wr_data = 32'h0;
        got_rdata = 32'hx; got_err = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (memread) begin nrd++; rd_addr = address; end
            if (memwrite) begin nwr++; wr_addr = address; wr_data = write_data; end
            if (memread && memwrite) both++;
            if (resp_valid) begin
                lat = k;
                got_rdata = resp_rdata;
                got_err = resp_err;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 8'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rd_wr", {30'd0, memread, memwrite}, 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_wdata", write_data, 32'h0);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);

        run_req(1'b0, 3'd0, 8'h04, 32'h0);
        check("lb_lat", lat, 2);
        check("lb_nrd", {nrd[15:0], nwr[15:0]}, 32'h0001_0000);
        check("lb_raddr", 32'(rd_addr), 32'h04);
        check("lb_data", got_rdata, 32'hFFFF_FFF2);
        check("lb_err", 32'(got_err), 32'd0);
        @(negedge clk);
        check("lb_hold", resp_rdata, 32'hFFFF_FFF2);

        run_req(1'b0, 3'd4, 8'h04, 32'h0);
        check("lbu_data", got_rdata, 32'h0000_00F2);
        run_req(1'b0, 3'd5, 8'h06, 32'h0);
        check("lhu_data", got_rdata, 32'h0000_8000);
        run_req(1'b0, 3'd1, 8'h06, 32'h0);
        check("lh_data", got_rdata, 32'hFFFF_8000);
        run_req(1'b0, 3'd0, 8'h07, 32'h0);
        check("lb3_data", got_rdata, 32'hFFFF_FF80);
        run_req(1'b0, 3'd2, 8'h04, 32'h0);
        check("lw_data", got_rdata, 32'h8000_00F2);

        run_req(1'b1, 3'd0, 8'h09, 32'h0000_00AB);
        check("sb_lat", lat, 3);
        check("sb_cnt", {nrd[15:0], nwr[15:0]}, 32'h0001_0001);
        check("sb_both", both, 0);
        check("sb_raddr", 32'(rd_addr), 32'h08);
        check("sb_waddr", 32'(wr_addr), 32'h08);
        check("sb_wdata", wr_data, 32'h0000_AB03);
        check("sb_rdata", got_rdata, 32'h0);
        check("sb_err", 32'(got_err), 32'd0);

        run_req(1'b1, 3'd1, 8'h0A, 32'h1234_5678);
        check("sh_wdata", wr_data, 32'h5678_AB03);

        run_req(1'b1, 3'd2, 8'h0C, 32'hDEAD_BEEF);
        check("sw_lat", lat, 2);
        check("sw_cnt", {nrd[15:0], nwr[15:0]}, 32'h0000_0001);
        check("sw_waddr", 32'(wr_addr), 32'h0C);
        check("sw_wdata", wr_data, 32'hDEAD_BEEF);
        run_req(1'b0, 3'd2, 8'h0C, 32'h0);
        check("lw_back", got_rdata, 32'hDEAD_BEEF);

        run_req(1'b0, 3'd2, 8'h02, 32'h0);
        check("lwmis_lat", lat, 1);
        check("lwmis_cnt", {nrd[15:0], nwr[15:0]}, 32'h0);
        check("lwmis_err", 32'(got_err), 32'd1);
        check("lwmis_data", got_rdata, 32'h0);
        run_req(1'b1, 3'd1, 8'h05, 32'hFFFF);
        check("shmis_lat", lat, 1);
        check("shmis_cnt", {nrd[15:0], nwr[15:0]}, 32'h0);
        check("shmis_err", 32'(got_err), 32'd1);
        run_req(1'b0, 3'd3, 8'h00, 32'h0);
        check("ld3_err", 32'(got_err), 32'd1);
        run_req(1'b1, 3'd4, 8'h00, 32'h0);
        check("st4_err", 32'(got_err), 32'd1);
        run_req(1'b0, 3'd0, 8'h04, 32'h0);
        check("ok_err", 32'(got_err), 32'd0);

        // Abort an SB by resetting during its READ cycle.
        req_we = 1'b1;
        req_funct3 = 3'd0;
        req_addr = 8'h08;
        req_wdata = 32'h0000_0055;
        req_valid = 1'b1;
        @(negedge clk);
        check("ab_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("ab_inread", 32'(memread), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ab_ready2", 32'(req_ready), 32'd1);
        check("ab_rd_wr", {30'd0, memread, memwrite}, 32'd0);
        check("ab_addr", 32'(address), 32'd0);
        check("ab_wdata", write_data, 32'h0);
        nwr = 0;
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (memwrite) nwr++;
            if (resp_valid) lat++;
        end
        check("ab_nowr", nwr, 0);
        check("ab_noresp", lat, 0);
        check("ab_mem", mem[2], 32'h0000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
